div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative 32-bit integer divider; the inverse companion of the pipelined array multiplier in the MIPS CPU datapath.
- Serves DIV/DIVU: computes quotient and remainder, signed or unsigned, one quotient bit per clock (restoring algorithm).
- Start/busy/done handshake to the HI/LO control logic; results held stable until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width; fixed latency WIDTH+1 clocks.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- a  input  WIDTH  dividend, sampled with start
- b  input  WIDTH  divisor, sampled with start
- q  output  WIDTH  quotient (registered)
- r  output  WIDTH  remainder (registered)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when q/r become valid

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on a clk edge with reset=1, state=IDLE and q=0, r=0, busy=0, done=0. All internal working registers are cleared. Reset has priority over start and over any in-flight operation, which is aborted.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - Latch sign info: sign_q = is_signed & (a[W-1]^b[W-1]); sign_r = is_signed & a[W-1].
  - Latch magnitudes |a| and |b|; take two's-complement negation only when is_signed and the MSB is set.
  - Clear the partial remainder. Set the bit counter to W-1. Go to RUN. busy=1 from edge k.
- IDLE, start=0: stay; busy=0.
- RUN: one restoring step per edge.
  - Shift {rem, dvd} left by 1.
  - trial = rem_shifted - |b|, computed in W+1 bits.
  - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise keep rem and the quotient LSB = 0.
  - Counter decrements. After the step with counter=0 (edge k+W), go to FIX.
- FIX (edge k+W+1):
  - q = sign_q ? -quo : quo; r = sign_r ? -rem : rem.
  - done=1 for exactly this following cycle. busy=0. Go to IDLE.
- Latency: start sampled at edge k gives done=1 and valid q/r in the cycle after edge k+W+1, i.e. 33 clocks for W=32. busy is high for W+1 cycles.
- q and r keep their values until the FIX of the next operation. They do not change on start.
- start while busy=1 is ignored, and no queueing occurs. start in the same cycle that done=1 is accepted, because the state is already IDLE.
- a and b may change after the start edge without affecting the operation.
- Divide by zero (b=0, detected at the start edge): fixed result q={W{1}}, r=a (raw dividend, no sign fixup). Latency is unchanged (W+1) and the handshake is identical.
- Signed overflow, a=0x80000000 and b=0xFFFFFFFF: q=0x80000000, r=0. The magnitude path produces 2^31, which wraps to 0x80000000.
- Semantics: quotient truncates toward zero; the remainder takes the sign of the dividend; a = q*b + r whenever b≠0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then unsigned: a=100, b=7, is_signed=0, start pulse -> busy high 33 cycles; done pulse 33 clocks after start; q=14, r=2.
- Signed: a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
- Boundaries:
  - a=0x80000000, b=0xFFFFFFFF signed -> q=0x80000000, r=0.
  - a=0xFFFFFFFF, b=1 unsigned -> q=0xFFFFFFFF, r=0.
  - a=3, b=10 -> q=0, r=3.
- Divide by zero: a=5, b=0 (signed and unsigned) -> q=0xFFFFFFFF, r=5, done at 33 clocks.
- Handshake:
  - A second start 10 cycles into an op with different operands is ignored; the first result is reported.
  - start asserted in the done cycle launches a new op, and its done pulse arrives 33 clocks later.
  - q/r stay stable between ops.
- Reset mid-op: reset at cycle 15 of RUN -> next edge gives q=0, r=0, busy=0, done=0, no done pulse. A fresh 100/7 then completes normally.

Source files
------------

// File: rtl/div_iter.sv
// rtl/div_iter.sv - Iterative restoring integer divider (DIV/DIVU), one quotient bit per clock
//
// Purpose:
//   Computes the quotient and remainder of a / b, signed or unsigned. Each
//   operation takes a fixed WIDTH+1 clocks after start is accepted: WIDTH
//   restoring steps on operand magnitudes, then one sign-fixup step. The
//   quotient truncates toward zero. The remainder takes the sign of the
//   dividend. Division by zero yields q = all ones and r = the raw dividend.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; aborts any operation in flight
//   start      request, sampled only while idle
//   is_signed  1 = two's complement (DIV), 0 = unsigned (DIVU)
//   a, b       dividend and divisor, sampled on the accepted start edge
//   q, r       registered quotient and remainder, held until the next result
//   busy       high while an operation is in flight
//   done       one-cycle pulse when q/r are updated

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;     // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] r_rem;     // partial remainder
  logic [WIDTH-1:0] r_dsr;     // divisor magnitude
  logic [WIDTH-1:0] r_a_raw;   // unmodified dividend, returned as r on divide by zero
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div0;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;

  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // {rem, dvd} shifted left by one: the new remainder candidate is WIDTH+1 bits.
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};

  // Trial subtraction is non-negative exactly when the WIDTH+1-bit candidate is
  // at least the divisor. In that case the difference is below the divisor, so
  // the low WIDTH bits of the subtraction hold it exactly.
  assign w_ge    = (w_rem_sh >= {1'b0, r_dsr});
  assign w_trial = w_rem_sh[WIDTH-1:0] - r_dsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dsr    <= '0;
      r_a_raw  <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r <= is_signed & a[WIDTH-1];
            r_dvd    <= w_a_mag;
            r_dsr    <= w_b_mag;
            r_a_raw  <= a;
            r_div0   <= (b == '0);
            r_rem    <= '0;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_RUN: begin
          r_rem <= w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // Signed overflow (most negative / -1) needs no special case: the
          // magnitude quotient 2^(WIDTH-1) already reads as the wrapped result.
          if (r_div0) begin
            r_q <= '1;
            r_r <= r_a_raw;
          end else begin
            r_q <= r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
            r_r <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - Directed self-checking bench for div_iter

module tb_div_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;

  int passed;
  int total;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .q         (q),
    .r         (r),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation, checks that q/r hold their old values on the start
  // edge, then waits (bounded) for done. Optionally pulses a second start with
  // other operands while busy. Leaves the bench in the done cycle.
  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xs, input logic [31:0] hold_q, input logic [31:0] hold_r,
                        input logic [31:0] exp_q, input logic [31:0] exp_r, input int inj);
    int lat;
    int bcnt;
    a = xa; b = xb; is_signed = xs; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_hold_q"}, q, hold_q);
    chk({tag, "_hold_r"}, r, hold_r);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == inj) begin
        start = 1'b1; a = 32'd50; b = 32'd3; is_signed = 1'b0;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      step();
      lat++;
      if (busy === 1'b1) bcnt++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd33);
    chk({tag, "_q"}, q, exp_q);
    chk({tag, "_r"}, r, exp_r);
  endtask

  task automatic idle_after_done(input string tag);
    step();
    chk({tag, "_done_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int dcnt;
    passed = 0;
    total  = 0;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    step();

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 32'd14, 32'd2, -1);
    idle_after_done("u100_7");
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    idle_after_done("s_m7_2");
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, -1);
    idle_after_done("s_7_m2");
    run_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, -1);
    idle_after_done("s_m100_7");
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h8000_0000, 32'd0, -1);
    idle_after_done("s_ovf");
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0, -1);
    idle_after_done("u_max_1");
    run_op("u_big_div", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, -1);
    idle_after_done("u_big_div");
    run_op("s_3_10", 32'd3, 32'd10, 1'b1, 32'd0, 32'h8000_0000, 32'd0, 32'd3, -1);
    idle_after_done("s_3_10");
    run_op("u_div0", 32'd5, 32'd0, 1'b0, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd5, -1);
    idle_after_done("u_div0");
    run_op("s_div0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, -1);
    idle_after_done("s_div0");
    run_op("s_neg_div0", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF9, -1);
    idle_after_done("s_neg_div0");

    // Second start 10 cycles in is ignored.
    run_op("ignore_start", 32'd100, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd14, 32'd2, 10);
    idle_after_done("ignore_start");
    for (int i = 0; i < 5; i++) step();
    chk("stable_q", q, 32'd14);
    chk("stable_r", r, 32'd2);
    chk("stable_busy", {31'b0, busy}, 32'd0);

    // Back-to-back: second op launched in the done cycle of the first.
    run_op("b2b_first", 32'd1000, 32'd10, 1'b0, 32'd14, 32'd2, 32'd100, 32'd0, -1);
    run_op("b2b_second", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd100, 32'd0, 32'h7FFF_FFFC, 32'd1, -1);
    idle_after_done("b2b_second");

    // Reset in the middle of RUN.
    a = 32'd100; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("mid_busy_before_rst", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", r, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) dcnt++;
    end
    chk("mid_rst_no_done", 32'(dcnt), 32'd0);
    run_op("after_rst", 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 32'd14, 32'd2, -1);
    idle_after_done("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
